// File: rtl/uart_tx.sv
// UART 8N1 transmitter: start bit, 8 data bits LSB first, stop bit.
// All outputs are registered; the line idles high.
module uart_tx #(
  parameter int c_CYCLES_PER_SECOND = 50000000,
  parameter int c_BAUD_RATE         = 115200,
  parameter int c_CYCLES_PER_BIT    = c_CYCLES_PER_SECOND / c_BAUD_RATE
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_BYTE,
  output logic       o_TX_SERIAL,
  output logic       o_TX_ACTIVE,
  output logic       o_TX_DONE
);

  localparam int c_CNT_W = $clog2(c_CYCLES_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_CYCLES_PER_BIT - 1);

  localparam logic [2:0] s_IDLE  = 3'd0;
  localparam logic [2:0] s_START = 3'd1;
  localparam logic [2:0] s_DATA  = 3'd2;
  localparam logic [2:0] s_STOP  = 3'd3;

  logic [2:0]         state_r, state_s;
  logic [c_CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]         idx_r, idx_s;
  logic [2:0]         idx_nx_s;
  logic [7:0]         shift_r, shift_s;
  logic               serial_r, serial_s;
  logic               active_r, active_s;
  logic               done_r, done_s;
  logic               cnt_last_s;

  assign cnt_last_s = (cnt_r == c_CNT_LAST);
  assign idx_nx_s   = idx_r + 3'd1;

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    idx_s    = idx_r;
    shift_s  = shift_r;
    serial_s = serial_r;
    active_s = active_r;
    done_s   = 1'b0;
    case (state_r)
      s_IDLE: begin
        serial_s = 1'b1;
        active_s = 1'b0;
        cnt_s    = '0;
        idx_s    = 3'd0;
        if (i_TX_DV) begin
          shift_s  = i_TX_BYTE;
          active_s = 1'b1;
          serial_s = 1'b0;
          state_s  = s_START;
        end else begin
          state_s  = s_IDLE;
        end
      end
      s_START: begin
        if (cnt_last_s) begin
          serial_s = shift_r[0];
          cnt_s    = '0;
          idx_s    = 3'd0;
          state_s  = s_DATA;
        end else begin
          cnt_s    = cnt_r + c_CNT_W'(1'b1);
        end
      end
      s_DATA: begin
        if (cnt_last_s) begin
          cnt_s = '0;
          if (idx_r == 3'd7) begin
            serial_s = 1'b1;
            state_s  = s_STOP;
          end else begin
            idx_s    = idx_nx_s;
            serial_s = shift_r[idx_nx_s];
          end
        end else begin
          cnt_s = cnt_r + c_CNT_W'(1'b1);
        end
      end
      s_STOP: begin
        if (cnt_last_s) begin
          cnt_s    = '0;
          active_s = 1'b0;
          done_s   = 1'b1;
          state_s  = s_IDLE;
        end else begin
          cnt_s    = cnt_r + c_CNT_W'(1'b1);
        end
      end
      default: begin
        // Corrupted state: park safely with the line high
        state_s  = s_IDLE;
        cnt_s    = '0;
        idx_s    = 3'd0;
        serial_s = 1'b1;
        active_s = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_r  <= s_IDLE;
      cnt_r    <= '0;
      idx_r    <= 3'd0;
      shift_r  <= 8'h00;
      serial_r <= 1'b1;
      active_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      shift_r  <= shift_s;
      serial_r <= serial_s;
      active_r <= active_s;
      done_r   <= done_s;
    end
  end

  assign o_TX_SERIAL = serial_r;
  assign o_TX_ACTIVE = active_r;
  assign o_TX_DONE   = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a fast instance (4 clocks/bit) and a default-rate instance,
// each checked every cycle against a frame-timing model and decoded by a model receiver.
module tb_uart_tx;

  localparam int CPB_A = 4;
  localparam int CPB_B = 434;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, dv_a, ser_a, act_a, done_a;
  logic [7:0] tx_byte_a;
  logic       rst_b = 1'b1, dv_b, ser_b, act_b, done_b;
  logic [7:0] tx_byte_b;

  uart_tx #(.c_CYCLES_PER_BIT(CPB_A)) dut_a (
    .i_CLK(clk), .i_RST(rst_a), .i_TX_DV(dv_a), .i_TX_BYTE(tx_byte_a),
    .o_TX_SERIAL(ser_a), .o_TX_ACTIVE(act_a), .o_TX_DONE(done_a)
  );

  uart_tx dut_b (
    .i_CLK(clk), .i_RST(rst_b), .i_TX_DV(dv_b), .i_TX_BYTE(tx_byte_b),
    .o_TX_SERIAL(ser_b), .o_TX_ACTIVE(act_b), .o_TX_DONE(done_b)
  );

  int n_pass = 0;
  int n_total = 0;
  logic en = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Expected {serial, active, done} k clocks after the accepting edge.
  function automatic logic [2:0] model_out(input int k, input logic [7:0] b, input int cpb);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    if (k >= 1 && k <= 10 * cpb) return {frame[(k - 1) / cpb], 1'b1, 1'b0};
    else if (k == 10 * cpb + 1) return 3'b101;
    else return 3'b100;
  endfunction

  // Model: clocks since the last accepted request (-1 = nothing sent since reset)
  int mk_a, mk_b;
  logic [7:0] mb_a, mb_b;

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      mk_a <= -1; mb_a <= 8'h00;
    end else if (mk_a < 1 || mk_a > 10 * CPB_A) begin
      if (dv_a === 1'b1) begin
        mk_a <= 1; mb_a <= tx_byte_a;
      end else if (mk_a > 10 * CPB_A) mk_a <= 10 * CPB_A + 2;
    end else mk_a <= mk_a + 1;
  end

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      mk_b <= -1; mb_b <= 8'h00;
    end else if (mk_b < 1 || mk_b > 10 * CPB_B) begin
      if (dv_b === 1'b1) begin
        mk_b <= 1; mb_b <= tx_byte_b;
      end else if (mk_b > 10 * CPB_B) mk_b <= 10 * CPB_B + 2;
    end else mk_b <= mk_b + 1;
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (en) begin
      chk("cmp_a {ser,act,done}", int'({ser_a, act_a, done_a}), int'(model_out(mk_a, mb_a, CPB_A)));
      chk("cmp_b {ser,act,done}", int'({ser_b, act_b, done_b}), int'(model_out(mk_b, mb_b, CPB_B)));
    end
  end

  // Model receivers: sample mid-bit after the first low sample; -1 marks a bad stop bit
  int rc_a = -1, rc_b = -1;
  logic [7:0] rs_a, rs_b;
  int rxq_a[$];
  int rxq_b[$];

  always @(negedge clk or posedge rst_a) begin
    if (rst_a) rc_a <= -1;
    else if (rc_a < 0) begin
      if (en && ser_a == 1'b0) rc_a <= 0;
    end else begin
      for (int i = 0; i < 8; i++)
        if (rc_a + 1 == CPB_A / 2 + CPB_A * (i + 1)) rs_a[i] <= ser_a;
      if (rc_a + 1 == CPB_A / 2 + CPB_A * 9) begin
        rxq_a.push_back(ser_a ? int'(rs_a) : -1);
        rc_a <= -1;
      end else rc_a <= rc_a + 1;
    end
  end

  always @(negedge clk or posedge rst_b) begin
    if (rst_b) rc_b <= -1;
    else if (rc_b < 0) begin
      if (en && ser_b == 1'b0) rc_b <= 0;
    end else begin
      for (int i = 0; i < 8; i++)
        if (rc_b + 1 == CPB_B / 2 + CPB_B * (i + 1)) rs_b[i] <= ser_b;
      if (rc_b + 1 == CPB_B / 2 + CPB_B * 9) begin
        rxq_b.push_back(ser_b ? int'(rs_b) : -1);
        rc_b <= -1;
      end else rc_b <= rc_b + 1;
    end
  end

  // Done-pulse counter and high-run lengths on the slow line
  int dn_a = 0;
  int hi_run_b = 0;
  int gaps_b[$];
  always @(negedge clk) begin
    if (en && done_a === 1'b1) dn_a <= dn_a + 1;
    if (en) begin
      if (ser_b === 1'b1) hi_run_b <= hi_run_b + 1;
      else begin
        if (hi_run_b > 0) gaps_b.push_back(hi_run_b);
        hi_run_b <= 0;
      end
    end
  end

  task automatic send_a(input logic [7:0] b);
    dv_a = 1'b1;
    tx_byte_a = b;
    @(posedge clk); #2;
    dv_a = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    logic [9:0] pat;
    int hc, ac, d0, n0, g0, r0;
    bit seen;
    dv_a = 1'b0; tx_byte_a = 8'h00;
    dv_b = 1'b0; tx_byte_b = 8'h00;
    step(3);
    rst_a = 1'b0; rst_b = 1'b0; en = 1'b1;

    // 1: reset between edges during a start bit, then long idle
    dv_b = 1'b1; tx_byte_b = 8'h5A;
    step(1);
    dv_b = 1'b0;
    step(100);
    chk("t1_start_low", ser_b, 0);
    rst_b = 1'b1;
    #1;
    chk("t1_rst_serial", ser_b, 1);
    chk("t1_rst_active", act_b, 0);
    chk("t1_rst_done", done_b, 0);
    step(1);
    rst_b = 1'b0;
    hc = 0;
    repeat (5000) begin @(negedge clk); if (ser_b === 1'b1) hc++; end
    chk("t1_idle_high_cycles", hc, 5000);
    step(1);

    // 2: 0x55, line pattern 0,1,0,1,... (first slot in bit 0)
    chk("t2_idle_before", ser_a, 1);
    d0 = dn_a;
    send_a(8'h55);
    pat = 10'b10_1010_1010;
    ac = 0;
    for (int j = 1; j <= 44; j++) begin
      @(negedge clk);
      if (j == 1) chk("t2_latency", ser_a, 0);
      if (j <= 40) chk("t2_line", ser_a, int'(pat[(j - 1) / 4]));
      else chk("t2_line_after", ser_a, 1);
      if (j == 41) chk("t2_done_pulse", done_a, 1);
      if (act_a === 1'b1) ac++;
    end
    chk("t2_active_cycles", ac, 40);
    step(1);
    chk("t2_done_count", dn_a - d0, 1);

    // 3: 0xA3 with the input byte changed right after acceptance
    n0 = rxq_a.size();
    send_a(8'hA3);
    tx_byte_a = 8'hFF;
    step(45);
    chk("t3_rx_count", rxq_a.size() - n0, 1);
    if (rxq_a.size() > n0) chk("t3_rx_byte", rxq_a[n0], 8'hA3);

    // 4: request during data bit 3 is ignored
    n0 = rxq_a.size();
    d0 = dn_a;
    send_a(8'h0F);
    step(16);
    dv_a = 1'b1; tx_byte_a = 8'hF0;
    step(1);
    dv_a = 1'b0;
    step(50);
    chk("t4_rx_count", rxq_a.size() - n0, 1);
    if (rxq_a.size() > n0) chk("t4_rx_byte", rxq_a[n0], 8'h0F);
    chk("t4_done_count", dn_a - d0, 1);

    // 5: back-to-back at the default rate, byte switched on done
    g0 = gaps_b.size();
    r0 = rxq_b.size();
    dv_b = 1'b1; tx_byte_b = 8'h00;
    seen = 1'b0;
    for (int t = 0; t < 6000 && !seen; t++) begin
      step(1);
      if (done_b === 1'b1) seen = 1'b1;
    end
    chk("t5_first_done_seen", int'(seen), 1);
    tx_byte_b = 8'hFF;
    step(1);
    dv_b = 1'b0;
    step(4500);
    chk("t5_rx_count", rxq_b.size() - r0, 2);
    if (rxq_b.size() > r0 + 1) begin
      chk("t5_rx_byte0", rxq_b[r0], 8'h00);
      chk("t5_rx_byte1", rxq_b[r0 + 1], 8'hFF);
    end
    chk("t5_gap_recorded", int'(gaps_b.size() > g0 + 1), 1);
    if (gaps_b.size() > g0 + 1) chk("t5_gap_len", gaps_b[g0 + 1], 435);

    // 6: reset during data bit 5, then a clean frame
    r0 = rxq_a.size();
    d0 = dn_a;
    send_a(8'h00);
    step(25);
    chk("t6_pre_low", ser_a, 0);
    rst_a = 1'b1;
    #1;
    chk("t6_rst_serial", ser_a, 1);
    chk("t6_rst_active", act_a, 0);
    step(2);
    rst_a = 1'b0;
    step(20);
    chk("t6_no_done", dn_a - d0, 0);
    chk("t6_idle_high", ser_a, 1);
    send_a(8'h3C);
    step(45);
    chk("t6_rx_count", rxq_a.size() - r0, 1);
    if (rxq_a.size() > r0) chk("t6_rx_byte", rxq_a[r0], 8'h3C);
    chk("t6_done_count", dn_a - d0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
